fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 12 +
 rtl/pc.sv | 12 +
 rtl/fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_fetch_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and PC constants for the instruction fetch controller
package fetch_pkg;
    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT,
        S_FAULT
    } state_t;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] PC_INC   = 32'd4;
endpackage

// File: rtl/pc.sv
// pc: program counter register, loads next_pc every cycle
module pc
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    output logic [31:0] pc_out
);
    always_ff @(posedge clk)
        pc_out <= reset ? RESET_PC : next_pc;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch FSM with redirect, halt, timeout and fault handling
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_addr
);
    state_t      state, state_n;
    logic        kill, kill_n, load, bad;
    logic [7:0]  cnt, cnt_n;
    logic [31:0] cur_pc, next_pc, fault_n;

    pc u_pc (.clk(clk), .reset(reset), .next_pc(next_pc), .pc_out(cur_pc));

    assign bad = redirect_valid && redirect_target[1:0] != 2'b00;

    always_comb begin
        state_n = state;
        next_pc = cur_pc;
        kill_n  = kill;
        cnt_n   = cnt;
        fault_n = fault_addr;
        load    = 1'b0;
        if (state inside {S_REQ, S_WAIT, S_HOLD} && bad) begin
            state_n = S_FAULT;
            fault_n = redirect_target;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) next_pc = redirect_target;
                    if (imem_req_ready) begin
                        state_n = S_WAIT;
                        cnt_n   = '0;
                        kill_n  = kill | redirect_valid;
                    end else if (halt_req) begin
                        state_n = S_HALT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill || redirect_valid) begin
                            kill_n  = 1'b0;
                            state_n = S_REQ;
                            if (redirect_valid) next_pc = redirect_target;
                        end else if (imem_rsp_err) begin
                            state_n = S_FAULT;
                            fault_n = cur_pc;
                        end else begin
                            load    = 1'b1;
                            state_n = S_HOLD;
                        end
                    end else begin
                        // a redirect before the response arrives must drop that response
                        if (redirect_valid) begin
                            next_pc = redirect_target;
                            kill_n  = 1'b1;
                        end
                        if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                            state_n = S_FAULT;
                            fault_n = cur_pc;
                        end else begin
                            cnt_n = cnt + 8'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || instr_ready) begin
                        next_pc = redirect_valid ? redirect_target : cur_pc + PC_INC;
                        state_n = halt_req ? S_HALT : S_REQ;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_REQ;
            kill       <= state == S_WAIT;
            cnt        <= '0;
            instr      <= '0;
            instr_pc   <= '0;
            fault_addr <= '0;
        end else begin
            state      <= state_n;
            kill       <= kill_n;
            cnt        <= cnt_n;
            fault_addr <= fault_n;
            if (load) begin
                instr    <= imem_rsp_data;
                instr_pc <= cur_pc;
            end
        end
    end

    assign imem_req_valid = !reset && state == S_REQ;
    assign instr_valid    = !reset && state == S_HOLD;
    assign halted         = !reset && state == S_HALT;
    assign fault          = !reset && state == S_FAULT;
    assign imem_addr      = cur_pc;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a behavioural model
module tb_fetch_ctrl;
    localparam int T = 16;
    localparam int MR = 0, MW = 1, MH = 2, MHALT = 3, MF = 4;

    logic        clk = 0, reset = 1;
    logic        imem_req_ready = 0, imem_rsp_valid = 0, imem_rsp_err = 0;
    logic        instr_ready = 0, redirect_valid = 0, halt_req = 0;
    logic [31:0] imem_rsp_data = 0, redirect_target = 0;
    logic        imem_req_valid, instr_valid, halted, fault;
    logic [31:0] imem_addr, instr, instr_pc, fault_addr;

    fetch_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt_req(halt_req), .halted(halted), .fault(fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int m_mode = MR, m_cnt = 0;
    bit m_kill = 0;
    logic [31:0] m_pc = 0, m_instr = 0, m_ipc = 0, m_faddr = 0;
    int rem = 0, lat = 1, stuck = 0;
    bit never = 0, err_next = 0;
    logic [31:0] pend_addr = 0;
    logic [31:0] fires[$], cons_pc[$], cons_d[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    endtask

    task automatic compare();
        bit r = reset;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, !r && m_mode == MR});
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, !r && m_mode == MH});
        chk("halted", {31'b0, halted}, {31'b0, !r && m_mode == MHALT});
        chk("fault", {31'b0, fault}, {31'b0, !r && m_mode == MF});
        if (!r && m_mode == MR) chk("imem_addr", imem_addr, m_pc);
        if (!r && m_mode == MH) begin
            chk("instr", instr, m_instr);
            chk("instr_pc", instr_pc, m_ipc);
        end
        if (!r && m_mode == MF) chk("fault_addr", fault_addr, m_faddr);
    endtask

    // spec rules applied once per rising edge, using the inputs of that cycle
    task automatic model_step();
        bit bad = redirect_valid && (redirect_target[1:0] != 2'b00);
        bit active = (m_mode == MR || m_mode == MW || m_mode == MH);
        if (reset) begin
            m_kill = (m_mode == MW);
            m_mode = MR; m_pc = 0; m_cnt = 0; m_instr = 0; m_ipc = 0; m_faddr = 0;
        end else if (active && bad) begin
            m_mode = MF; m_faddr = redirect_target;
        end else if (m_mode == MR) begin
            logic [31:0] np = redirect_valid ? redirect_target : m_pc;
            if (imem_req_ready) begin
                m_mode = MW; m_cnt = 0; m_kill = m_kill || redirect_valid;
            end else if (halt_req) m_mode = MHALT;
            m_pc = np;
        end else if (m_mode == MW) begin
            if (imem_rsp_valid) begin
                if (m_kill || redirect_valid) begin
                    m_kill = 0; m_mode = MR;
                    if (redirect_valid) m_pc = redirect_target;
                end else if (imem_rsp_err) begin
                    m_mode = MF; m_faddr = m_pc;
                end else begin
                    m_instr = imem_rsp_data; m_ipc = m_pc; m_mode = MH;
                end
            end else begin
                logic [31:0] old = m_pc;
                if (redirect_valid) begin m_pc = redirect_target; m_kill = 1; end
                m_cnt++;
                if (m_cnt >= T) begin m_mode = MF; m_faddr = old; end
            end
        end else if (m_mode == MH) begin
            if (redirect_valid || instr_ready) begin
                m_pc = redirect_valid ? redirect_target : m_pc + 32'd4;
                m_mode = halt_req ? MHALT : MR;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        if (imem_req_valid && imem_req_ready) begin
            fires.push_back(imem_addr);
            pend_addr = imem_addr;
            rem = never ? 0 : lat;
        end
        if (instr_valid && instr_ready) begin
            cons_pc.push_back(instr_pc);
            cons_d.push_back(instr);
        end
        model_step();
        @(posedge clk);
        #1;
        imem_rsp_valid = 0;
        imem_rsp_err = 1'($urandom_range(0, 1));
        imem_rsp_data = $urandom;
        if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                imem_rsp_valid = 1;
                imem_rsp_data = pend_addr ^ 32'hDEAD0000;
                imem_rsp_err = err_next;
            end
        end
    endtask

    initial begin
        int nf;
        logic [31:0] t;
        logic [1:0] lo;
        tick(); tick();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_halted_fault", {30'b0, halted, fault}, 32'd0);
        chk("rst_pc", imem_addr, 32'h0);
        reset = 0; imem_req_ready = 1; instr_ready = 1;
        repeat (9) tick();
        chk("seq_nfires", fires.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("seq_fire_addr", fires[i], 32'(4 * i));
            chk("seq_instr_pc", cons_pc[i], 32'(4 * i));
        end
        chk("seq_instr", cons_d[2], 32'hDEAD0008);
        instr_ready = 0;
        tick(); tick();
        chk("hold_valid", {31'b0, instr_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("hold_pc", instr_pc, 32'hC);
            chk("hold_instr", instr, 32'hDEAD000C);
            chk("hold_noreq", {31'b0, imem_req_valid}, 32'd0);
            tick();
        end
        instr_ready = 1;
        tick();
        chk("after_hold_addr", imem_addr, 32'h10);
        lat = 3;
        tick();
        redirect_valid = 1; redirect_target = 32'h40;
        tick();
        redirect_valid = 0;
        tick(); tick();
        chk("redir_req", {31'b0, imem_req_valid}, 32'd1);
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_dropped", {31'b0, instr_valid}, 32'd0);
        lat = 1; imem_req_ready = 0;
        redirect_valid = 1; redirect_target = 32'h42;
        tick();
        redirect_valid = 0;
        chk("misalign_fault", {31'b0, fault}, 32'd1);
        chk("misalign_addr", fault_addr, 32'h42);
        nf = fires.size(); imem_req_ready = 1;
        tick(); tick();
        chk("misalign_noreq", fires.size(), nf);
        reset = 1; tick(); reset = 0;
        imem_req_ready = 0; redirect_valid = 1; redirect_target = 32'hC;
        tick();
        redirect_valid = 0; imem_req_ready = 1; never = 1;
        tick();
        repeat (T - 1) tick();
        chk("timeout_early", {31'b0, fault}, 32'd0);
        tick();
        chk("timeout_fault", {31'b0, fault}, 32'd1);
        chk("timeout_addr", fault_addr, 32'hC);
        reset = 1; tick(); reset = 0; never = 0;
        imem_req_ready = 0; redirect_valid = 1; redirect_target = 32'h10;
        tick();
        redirect_valid = 0; imem_req_ready = 1; err_next = 1;
        tick(); tick();
        chk("err_fault", {31'b0, fault}, 32'd1);
        chk("err_addr", fault_addr, 32'h10);
        err_next = 0;
        reset = 1; tick(); reset = 0;
        imem_req_ready = 0; redirect_valid = 1; redirect_target = 32'hFFFFFFFC;
        tick();
        redirect_valid = 0; imem_req_ready = 1;
        tick(); tick(); tick();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_req", {31'b0, imem_req_valid}, 32'd1);
        tick(); tick();
        halt_req = 1;
        tick();
        chk("halt_halted", {31'b0, halted}, 32'd1);
        chk("halt_noreq", {30'b0, imem_req_valid, instr_valid}, 32'd0);
        halt_req = 0; reset = 1;
        tick();
        chk("halt_reset_pc", imem_addr, 32'h0);
        reset = 0;
        #1;
        chk("halt_reset_req", {31'b0, imem_req_valid}, 32'd1);
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = $urandom_range(0, 9) < 7;
            instr_ready = $urandom_range(0, 9) < 6;
            halt_req = $urandom_range(0, 49) == 0;
            redirect_valid = $urandom_range(0, 19) == 0;
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hC)) : ($urandom & 32'h3FC);
            lo = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) t[1:0] = lo;
            redirect_target = t;
            lat = $urandom_range(1, 4);
            never = $urandom_range(0, 39) == 0;
            err_next = $urandom_range(0, 29) == 0;
            stuck = (halted || fault) ? stuck + 1 : 0;
            reset = (stuck > 3) || ($urandom_range(0, 299) == 0);
            tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
